// File: rtl/ts_channel_selector_pkg.sv
// Shared constants and types for the TS channel selector.
package ts_channel_selector_pkg;
   localparam logic [7:0] SYNC_BYTE = 8'h47;
   localparam int         NUM_CH    = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOCKED  = 2'd1,
      ST_PENDING = 2'd2
   } sel_state_e;

   // One byte slot of a TS stream
   typedef struct packed {
      logic       valid;
      logic       sop;
      logic [7:0] data;
   } ts_beat_t;
endpackage

// File: rtl/ts_channel_selector_monitor.sv
// Per-channel TS monitor: presence timer, sync/TEI check, saturating error counter.
module ts_channel_selector_monitor
   import ts_channel_selector_pkg::*;
#(
   parameter logic [19:0] LOSS_TIMEOUT = 20'd4096
) (
   input  logic       clk,
   input  logic       rst,
   input  ts_beat_t   beat,
   input  logic       clear,
   output logic       present,
   output logic [7:0] err_count
);

   logic [19:0] timer;
   logic        hdr2;
   logic        good_sop;
   logic        err_hit;

   assign good_sop = beat.valid & beat.sop & (beat.data == SYNC_BYTE);
   // Bad sync on the sop byte, or TEI set on the byte right after a sop
   assign err_hit  = beat.valid & (beat.sop ? (beat.data != SYNC_BYTE)
                                            : (hdr2 & beat.data[7]));

   // Presence: reload on a good sop, drop once the timer reaches the timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         timer   <= 20'd0;
         present <= 1'b0;
      end else if (good_sop) begin
         timer   <= 20'd0;
         present <= 1'b1;
      end else if (timer != LOSS_TIMEOUT) begin
         timer <= timer + 20'd1;
         if (timer + 20'd1 == LOSS_TIMEOUT)
            present <= 1'b0;
      end
   end

   // Marks the next valid byte as the second header byte (carries TEI)
   always_ff @(posedge clk) begin
      if (rst)             hdr2 <= 1'b0;
      else if (beat.valid) hdr2 <= beat.sop;
   end

   // Saturating error counter; a clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || clear)
         err_count <= 8'd0;
      else if (err_hit && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end

endmodule

// File: rtl/ts_channel_selector.sv
// QoS channel selector: monitors four TS streams, picks a target channel and
// forwards it, switching only on packet boundaries.
module ts_channel_selector
   import ts_channel_selector_pkg::*;
#(
   parameter logic [19:0] LOSS_TIMEOUT = 20'd4096,
   parameter logic [7:0]  ERR_THRESH   = 8'd16,
   parameter logic [15:0] PRESCALE     = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fallback_enable,
   input  logic        manual_enable,
   input  logic [1:0]  manual_channel,
   input  logic [7:0]  channel_priority,
   input  logic [19:0] reset_timer,
   input  logic [3:0]  ts_valid,
   input  logic [3:0]  ts_sop,
   input  logic [31:0] ts_data,
   output logic        out_valid,
   output logic        out_sop,
   output logic [7:0]  out_data,
   output logic [1:0]  active_channel,
   output logic [3:0]  signal_present,
   output logic [7:0]  error_count_ch0,
   output logic [7:0]  error_count_ch1,
   output logic [7:0]  error_count_ch2,
   output logic [7:0]  error_count_ch3
);

   ts_beat_t   beat [NUM_CH];
   logic [7:0] err  [NUM_CH];
   logic       clear;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
      assign beat[g] = '{valid: ts_valid[g], sop: ts_sop[g], data: ts_data[8*g +: 8]};
      ts_channel_selector_monitor #(.LOSS_TIMEOUT(LOSS_TIMEOUT)) u_mon (
         .clk       (clk),
         .rst       (rst),
         .beat      (beat[g]),
         .clear     (clear),
         .present   (signal_present[g]),
         .err_count (err[g])
      );
   end

   assign error_count_ch0 = err[0];
   assign error_count_ch1 = err[1];
   assign error_count_ch2 = err[2];
   assign error_count_ch3 = err[3];

   // ---------------- error-clear timebase ----------------
   logic [15:0] pre_cnt;
   logic [19:0] tick_cnt;
   logic [19:0] rt_q;
   logic        tick;
   logic        rt_chg;

   assign rt_chg = (reset_timer != rt_q);
   assign tick   = (pre_cnt == PRESCALE - 16'd1);
   assign clear  = ~rt_chg & tick & (reset_timer != 20'd0) &
                   (tick_cnt + 20'd1 == reset_timer);

   // Prescaler and tick counter; a new reset_timer value restarts the period
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt  <= 16'd0;
         tick_cnt <= 20'd0;
         rt_q     <= 20'd0;
      end else begin
         rt_q <= reset_timer;
         if (rt_chg) begin
            pre_cnt  <= 16'd0;
            tick_cnt <= 20'd0;
         end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            if (clear)     tick_cnt <= 20'd0;
            else if (tick) tick_cnt <= tick_cnt + 20'd1;
         end
      end
   end

   // ---------------- target selection ----------------
   logic [1:0] target;
   logic [1:0] cand;
   logic       found;

   // Manual, fixed-priority, or first eligible channel in priority order
   always_comb begin
      target = active_channel;
      cand   = 2'd0;
      found  = 1'b0;
      if (manual_enable)
         target = manual_channel;
      else if (!fallback_enable)
         target = channel_priority[1:0];
      else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cand = channel_priority[2*i +: 2];
            if (!found && signal_present[cand] && err[cand] < ERR_THRESH) begin
               target = cand;
               found  = 1'b1;
            end
         end
      end
   end

   // ---------------- FSM ----------------
   sel_state_e state, state_nxt;
   logic       tgt_sop;
   logic       sw;
   logic       fwd;
   logic [1:0] src;

   assign tgt_sop = beat[target].valid & beat[target].sop;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state: lock on a target sop, wait in PENDING while target differs
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (tgt_sop) state_nxt = ST_LOCKED;
         ST_LOCKED,
         ST_PENDING: begin
            if (sw)                              state_nxt = ST_LOCKED;
            else if (target != active_channel)   state_nxt = ST_PENDING;
            else                                 state_nxt = ST_LOCKED;
         end
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Switch decision and forwarding enable (lost active channel is muted)
   always_comb begin
      sw  = tgt_sop & ((state == ST_IDLE) | (target != active_channel));
      src = sw ? target : active_channel;
      fwd = sw | ((state != ST_IDLE) &
                  (signal_present[active_channel] | manual_enable));
   end

   // Registered output stage: one cycle from input byte to out_*
   always_ff @(posedge clk) begin
      if (rst) begin
         active_channel <= 2'd0;
         out_valid      <= 1'b0;
         out_sop        <= 1'b0;
         out_data       <= 8'd0;
      end else begin
         if (sw) active_channel <= target;
         out_valid <= fwd & beat[src].valid;
         out_sop   <= fwd & beat[src].valid & beat[src].sop;
         out_data  <= (fwd & beat[src].valid) ? beat[src].data : 8'd0;
      end
   end

endmodule
